// File: rtl/data_bus_router_if.sv
// rtl/data_bus_router_if.sv - CPU data-port and target-side bus bundle for data_bus_router
interface data_bus_router_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                      cpu_req;
  logic                      cpu_we;
  logic [ADDR_WIDTH-1:0]     cpu_addr;
  logic [DATA_WIDTH-1:0]     cpu_wdata;
  logic [DATA_WIDTH/8-1:0]   cpu_be;
  logic                      cpu_ready;
  logic                      cpu_err;
  logic [DATA_WIDTH-1:0]     cpu_rdata;
  logic [2:0]                tgt_req;
  logic                      tgt_we;
  logic [ADDR_WIDTH-1:0]     tgt_addr;
  logic [DATA_WIDTH-1:0]     tgt_wdata;
  logic [DATA_WIDTH/8-1:0]   tgt_be;
  logic [2:0]                tgt_ack;
  logic [DATA_WIDTH-1:0]     tgt_rdata0;
  logic [DATA_WIDTH-1:0]     tgt_rdata1;
  logic [DATA_WIDTH-1:0]     tgt_rdata2;

  // Router side: takes the CPU request, drives the targets, returns the response.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  tgt_ack, tgt_rdata0, tgt_rdata1, tgt_rdata2,
    output cpu_ready, cpu_err, cpu_rdata,
    output tgt_req, tgt_we, tgt_addr, tgt_wdata, tgt_be
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output tgt_ack, tgt_rdata0, tgt_rdata1, tgt_rdata2,
    input  cpu_ready, cpu_err, cpu_rdata,
    input  tgt_req, tgt_we, tgt_addr, tgt_wdata, tgt_be
  );
endinterface

// File: rtl/data_bus_router.sv
// rtl/data_bus_router.sv - steers one CPU data request to RAM, MMIO or ROM and returns the response
module data_bus_router #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic               clk_i,
  input  logic               rst_i,
  data_bus_router_if.slave   bus_io
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_ERR} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              sel_q, sel_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [2:0]              req_q, req_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [BE_WIDTH-1:0]     be_q, be_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [1:0]              cpu_sel;
  logic                    ack_hit;
  logic [DATA_WIDTH-1:0]   tgt_rdata_sel;

  assign cpu_sel = bus_io.cpu_addr[ADDR_WIDTH-1 -: 2];
  // req_q is one-hot on the selected target while waiting, so masking filters stray acks.
  assign ack_hit = |(bus_io.tgt_ack & req_q);

  always_comb begin
    tgt_rdata_sel = bus_io.tgt_rdata2;
    case (sel_q)
      2'd0:    tgt_rdata_sel = bus_io.tgt_rdata0;
      2'd1:    tgt_rdata_sel = bus_io.tgt_rdata1;
      default: tgt_rdata_sel = bus_io.tgt_rdata2;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_io.cpu_req) begin
          we_d    = bus_io.cpu_we;
          addr_d  = bus_io.cpu_addr;
          wdata_d = bus_io.cpu_wdata;
          be_d    = bus_io.cpu_be;
          sel_d   = cpu_sel;
          cnt_d   = 8'd0;
          if (cpu_sel == 2'd3 || (cpu_sel == 2'd2 && bus_io.cpu_we)) begin
            state_d = ST_ERR;
            ready_d = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ST_WAIT;
            req_d   = 3'b001 << cpu_sel;
          end
        end
      end
      ST_WAIT: begin
        if (ack_hit) begin
          state_d = ST_RESP;
          req_d   = 3'b000;
          ready_d = 1'b1;
          rdata_d = we_q ? '0 : tgt_rdata_sel;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERR;
          req_d   = 3'b000;
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'd0;
      cnt_q   <= 8'd0;
      req_q   <= 3'b000;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus_io.tgt_req   = req_q;
  assign bus_io.tgt_we    = we_q;
  assign bus_io.tgt_addr  = addr_q;
  assign bus_io.tgt_wdata = wdata_q;
  assign bus_io.tgt_be    = be_q;
  assign bus_io.cpu_ready = ready_q;
  assign bus_io.cpu_err   = err_q;
  assign bus_io.cpu_rdata = rdata_q;
endmodule

// File: tb/tb_data_bus_router.sv
// tb/tb_data_bus_router.sv - table-driven directed bench for data_bus_router
module tb_data_bus_router;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  data_bus_router_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  data_bus_router #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(15)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [2:0]  ack_bits;
    int          ack_cyc;
    logic [2:0]  bad_bits;
    int          bad_cyc;
    logic [2:0]  exp_req;
    int          exp_rdy;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx);
    vec_t        v;
    int          rdy_cyc;
    int          hold_bad;
    logic [2:0]  req1;
    logic [2:0]  rdy_req;
    logic        got_err;
    logic [31:0] got_rdata;
    v = vecs[idx];
    rdy_cyc = 0; hold_bad = 0; req1 = 3'b111; rdy_req = 3'b111;
    got_err = 1'bx; got_rdata = 'x;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = v.we;
    bus.cpu_addr  = v.addr;
    bus.cpu_wdata = v.wdata;
    bus.cpu_be    = v.be;
    for (int cyc = 1; cyc <= 40 && rdy_cyc == 0; cyc++) begin
      tick();
      bus.tgt_ack = ((cyc == v.ack_cyc) ? v.ack_bits : 3'b000) |
                    ((cyc == v.bad_cyc) ? v.bad_bits : 3'b000);
      if (cyc == 1) req1 = bus.tgt_req;
      if (bus.cpu_ready) begin
        rdy_cyc   = cyc;
        got_err   = bus.cpu_err;
        got_rdata = bus.cpu_rdata;
        rdy_req   = bus.tgt_req;
      end else if (bus.tgt_req != v.exp_req || bus.tgt_addr != v.addr || bus.tgt_we != v.we ||
                   bus.tgt_wdata != v.wdata || bus.tgt_be != v.be || bus.cpu_err) begin
        hold_bad++;
      end
    end
    bus.cpu_req = 1'b0;
    chk($sformatf("v%0d_req_cycle1", idx), 32'(req1), 32'(v.exp_req));
    chk($sformatf("v%0d_ready_cycle", idx), 32'(rdy_cyc), 32'(v.exp_rdy));
    chk($sformatf("v%0d_err", idx), 32'(got_err), 32'(v.exp_err));
    chk($sformatf("v%0d_rdata", idx), got_rdata, v.exp_rdata);
    chk($sformatf("v%0d_req_dropped", idx), 32'(rdy_req), 32'd0);
    chk($sformatf("v%0d_wait_hold", idx), 32'(hold_bad), 32'd0);
    tick();
    bus.tgt_ack = (rdy_cyc + 1 == v.ack_cyc) ? v.ack_bits : 3'b000;
    chk($sformatf("v%0d_ready_one_cycle", idx), 32'(bus.cpu_ready), 32'd0);
    tick();
    bus.tgt_ack = 3'b000;
    chk($sformatf("v%0d_idle_after", idx), {28'd0, bus.tgt_req, bus.cpu_ready}, 32'd0);
  endtask

  initial begin
    //            we    addr           wdata          be      ackb    ackc badb   badc exp_req rdy err  rdata
    vecs[0]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF,   3'b001, 1,  3'b000, 0,  3'b001, 2,  1'b0, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b1, 32'h4000_0004, 32'h0000_00A5, 4'b0001,3'b010, 4,  3'b000, 0,  3'b010, 5,  1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h4000_0100, 32'h0,         4'hF,   3'b010, 1,  3'b000, 0,  3'b010, 2,  1'b0, 32'hCAFE_F00D};
    vecs[3]  = '{1'b0, 32'hC000_0000, 32'h0,         4'hF,   3'b000, 0,  3'b000, 0,  3'b000, 1,  1'b1, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0004, 32'h0,         4'hF,   3'b001, 1,  3'b000, 0,  3'b001, 2,  1'b0, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b1, 32'h8000_0000, 32'h1234,      4'hF,   3'b000, 0,  3'b000, 0,  3'b000, 1,  1'b1, 32'h0};
    vecs[6]  = '{1'b0, 32'h8000_0020, 32'h0,         4'hF,   3'b100, 2,  3'b000, 0,  3'b100, 3,  1'b0, 32'h1234_5678};
    vecs[7]  = '{1'b0, 32'h8000_0000, 32'h0,         4'hF,   3'b100, 17, 3'b000, 0,  3'b100, 16, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_0020, 32'h0,         4'hF,   3'b001, 5,  3'b010, 2,  3'b001, 6,  1'b0, 32'hDEAD_BEEF};
    vecs[9]  = '{1'b0, 32'h0000_0030, 32'h0,         4'hF,   3'b001, 15, 3'b000, 0,  3'b001, 16, 1'b0, 32'hDEAD_BEEF};
    vecs[10] = '{1'b1, 32'h0000_0008, 32'h1122_3344, 4'hF,   3'b001, 3,  3'b000, 0,  3'b001, 4,  1'b0, 32'h0};

    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_be = '0;
    bus.tgt_ack = 3'b000;
    bus.tgt_rdata0 = 32'hDEAD_BEEF;
    bus.tgt_rdata1 = 32'hCAFE_F00D;
    bus.tgt_rdata2 = 32'h1234_5678;

    rst = 1'b1;
    tick();
    tick();
    chk("rst_tgt_req",   32'(bus.tgt_req), 32'd0);
    chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    chk("rst_cpu_err",   32'(bus.cpu_err), 32'd0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    chk("rst_tgt_fields", {27'd0, bus.tgt_we, bus.tgt_be} | bus.tgt_addr | bus.tgt_wdata, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) run_vec(i);

    // Reset lands in cycle 3 of an MMIO read; the transaction must vanish silently.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h4000_0000; bus.cpu_be = 4'hF;
    tick();
    chk("rstw_req_cycle1", 32'(bus.tgt_req), 32'b010);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.cpu_req = 1'b0;
    chk("rstw_req_dropped", 32'(bus.tgt_req), 32'd0);
    chk("rstw_no_ready", 32'(bus.cpu_ready), 32'd0);
    chk("rstw_rdata_cleared", bus.cpu_rdata, 32'd0);
    tick();
    bus.tgt_ack = 3'b010;
    tick();
    bus.tgt_ack = 3'b000;
    chk("rstw_late_ack_ignored", {28'd0, bus.tgt_req, bus.cpu_ready}, 32'd0);
    tick();
    run_vec(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
